aes_req_arbiter: RTL and testbench

AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

---
 rtl/aes_req_arbiter.sv | 149 ++++++++++++++
 tb/tb_aes_req_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: round-robin front end that shares one AES-128 decryption
// core between two requesters. Each job goes IDLE -> BUSY -> RELEASE -> RESP.
// The core's key/ciphertext are latched at grant, so requesters may change
// their inputs while the job is running.
// Optional BUSY watchdog: define AES_ARB_TIMEOUT_EN. The limit is set by
// TIMEOUT_CYCLES. In the default build, err0/err1/aes_core_reset are tied to 0.
module aes_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         req0,
  input  logic         req1,
  input  logic [127:0] key0,
  input  logic [127:0] key1,
  input  logic [127:0] msg0,
  input  logic [127:0] msg1,
  output logic         grant0,
  output logic         grant1,
  output logic         valid0,
  output logic         valid1,
  output logic         err0,
  output logic         err1,
  output logic [127:0] dec_out,
  output logic         aes_start,
  output logic [127:0] aes_key,
  output logic [127:0] aes_msg_enc,
  input  logic         aes_done,
  input  logic [127:0] aes_msg_dec,
  output logic         aes_core_reset
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE, RESP} state_t;

  state_t state, state_n;
  logic   owner;        // requester being served: 0 or 1
  logic   rr;           // priority pointer: 0 = req0 wins a tie
  logic   rel_cnt;      // counts the two RELEASE cycles
  logic   pick1;        // arbitration result when leaving IDLE
  logic   timeout_hit;  // watchdog expired this BUSY cycle

  // req1 wins if it is the only requester, or if both request and rr points to it.
  assign pick1 = req1 & (~req0 | rr);

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] to_cnt;
  logic          timed_out;

  // aes_done takes priority over a timeout that fires in the same cycle.
  assign timeout_hit = (state == BUSY) && !aes_done &&
                       (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: zero outside BUSY, +1 per BUSY cycle. It also
  // remembers whether the current job was ended by the watchdog.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      to_cnt    <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state == BUSY) to_cnt <= to_cnt + 1'b1;
      else               to_cnt <= '0;
      if (state == IDLE)     timed_out <= 1'b0;
      else if (timeout_hit)  timed_out <= 1'b1;
    end
  end

  assign aes_core_reset = timeout_hit;
  assign err0           = valid0 & timed_out;
  assign err1           = valid1 & timed_out;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit        = 1'b0;
  assign aes_core_reset     = 1'b0;
  assign err0               = 1'b0;
  assign err1               = 1'b0;
`endif

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking (<=). Every flop then samples
  // pre-edge values, whatever the order in which the blocks are evaluated.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic and decoded outputs.
  // NOTE: each output gets a default value first, so no path leaves it
  // unassigned. Without the defaults a latch would be inferred.
  always_comb begin
    state_n   = state;
    aes_start = 1'b0;
    grant0    = 1'b0;
    grant1    = 1'b0;
    valid0    = 1'b0;
    valid1    = 1'b0;
    unique case (state)
      IDLE:    if (req0 | req1) state_n = BUSY;
      BUSY: begin
        aes_start = 1'b1;
        if (timeout_hit)   state_n = RESP;
        else if (aes_done) state_n = RELEASE;
      end
      RELEASE: if (rel_cnt) state_n = RESP;
      RESP: begin
        valid0  = ~owner;
        valid1  = owner;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE) begin
      grant0 = ~owner;
      grant1 = owner;
    end
  end

  // Datapath: latch the job at grant, capture the result, and advance rr.
  // NOTE: the 128-bit key/msg/result registers are few and must read as 0
  // after reset. They are cleared here, unlike memories, which would not be.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      owner       <= 1'b0;
      rr          <= 1'b0;
      rel_cnt     <= 1'b0;
      aes_key     <= '0;
      aes_msg_enc <= '0;
      dec_out     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          rel_cnt <= 1'b0;
          if (req0 | req1) begin
            owner       <= pick1;
            aes_key     <= pick1 ? key1 : key0;
            aes_msg_enc <= pick1 ? msg1 : msg0;
          end
        end
        BUSY:    if (aes_done) dec_out <= aes_msg_dec;
        RELEASE: rel_cnt <= ~rel_cnt;
        RESP:    rr <= ~owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb_aes_req_arbiter: directed bench for aes_req_arbiter. A small behavioural
// core stands in for the AES engine. It returns the FIPS-197 plaintext for
// the two known key/ciphertext pairs, and key^msg for anything else. The done
// latency is programmable, and done can be held low to exercise the watchdog.
module tb_aes_req_arbiter;

  localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;

  logic         CLK, RESET;
  logic         req0, req1;
  logic [127:0] key0, key1, msg0, msg1;
  logic         grant0, grant1, valid0, valid1, err0, err1;
  logic [127:0] dec_out;
  logic         aes_start;
  logic [127:0] aes_key, aes_msg_enc;
  logic         aes_done = 1'b0;
  logic [127:0] aes_msg_dec = '0;
  logic         aes_core_reset;

  int checks = 0;
  int errors = 0;
  int v0_cnt = 0, v1_cnt = 0, overlap = 0, err_seen = 0;
  int core_cnt = 0;
  int core_lat = 4;
  bit core_stuck = 1'b0;

  aes_req_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .req0(req0), .req1(req1),
    .key0(key0), .key1(key1), .msg0(msg0), .msg1(msg1),
    .grant0(grant0), .grant1(grant1),
    .valid0(valid0), .valid1(valid1),
    .err0(err0), .err1(err1),
    .dec_out(dec_out),
    .aes_start(aes_start), .aes_key(aes_key), .aes_msg_enc(aes_msg_enc),
    .aes_done(aes_done), .aes_msg_dec(aes_msg_dec),
    .aes_core_reset(aes_core_reset)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] c);
    if (k == KA && c == CA) return PA;
    if (k == KB && c == CB) return PB;
    return k ^ c;
  endfunction

  // Behavioural core: after core_lat start cycles, raise done (unless stuck).
  // Done is held while start stays high, and cleared when start drops.
  always @(negedge CLK) begin
    if (aes_start !== 1'b1 || aes_core_reset === 1'b1) begin
      core_cnt = 0;
      aes_done = 1'b0;
    end else begin
      core_cnt = core_cnt + 1;
      if (!core_stuck && core_cnt >= core_lat) begin
        aes_done    = 1'b1;
        aes_msg_dec = core_fn(aes_key, aes_msg_enc);
      end
    end
  end

  // Cycle monitor: valid pulses, one-hot violations, and error flags seen.
  always @(negedge CLK) begin
    if (grant0 === 1'b1 && grant1 === 1'b1) overlap++;
    if (valid0 === 1'b1 && valid1 === 1'b1) overlap++;
    if (valid0 === 1'b1) v0_cnt++;
    if (valid1 === 1'b1) v1_cnt++;
    if (err0 === 1'b1 || err1 === 1'b1 || aes_core_reset === 1'b1) err_seen++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget, output int cycles);
    int i;
    cycles = 0;
    i = 0;
    while (cycles == 0 && i < budget) begin
      @(negedge CLK);
      i++;
      if (valid0 === 1'b1 || valid1 === 1'b1) cycles = i;
    end
    if (cycles == 0) begin
      checks++;
      assert (cycles != 0) else begin
        errors++;
        $error("FAIL %s: observed no valid expected valid within %0d cycles", tag, budget);
      end
    end
  endtask

  initial begin
    int n;
    int vb0, vb1;
    RESET = 1'b1; req0 = 1'b0; req1 = 1'b0;
    key0 = '0; key1 = '0; msg0 = '0; msg1 = '0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_ctrl", {grant0, grant1, valid0, valid1, err0, err1, aes_start, aes_core_reset}, '0);
    check("rst_dec_out", dec_out, '0);
    check("rst_aes_key", aes_key, '0);
    check("rst_aes_msg", aes_msg_enc, '0);
    RESET = 1'b0;
    @(negedge CLK);
    check("idle_no_req", {grant0, grant1, aes_start}, '0);

    // Single request on req0, with key0/msg0 changed while the job is BUSY
    vb0 = v0_cnt;
    key0 = KA; msg0 = CA; req0 = 1'b1;
    @(negedge CLK);
    check("t1_busy_grant", {grant0, grant1, aes_start}, 3'b101);
    check("t1_key_latch", aes_key, KA);
    check("t1_msg_latch", aes_msg_enc, CA);
    key0 = ~KA; msg0 = ~CA;
    @(negedge CLK);
    check("t1_key_stable", aes_key, KA);
    check("t1_msg_stable", aes_msg_enc, CA);
    wait_valid("t1_wait", 30, n);
    check("t1_latency", n, 5);
    check("t1_valid_owner", {valid0, valid1}, 2'b10);
    check("t1_dec_out", dec_out, PA);
    check("t1_err0", err0, 1'b0);
    req0 = 1'b0;
    @(negedge CLK);
    check("t1_idle_after", {grant0, valid0, aes_start}, '0);
    repeat (3) @(negedge CLK);
    check("t1_one_pulse", v0_cnt - vb0, 1);
    check("t1_dec_held", dec_out, PA);

    // Both requests held after reset: round-robin order 0,1,0,1
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    vb0 = v0_cnt; vb1 = v1_cnt;
    key0 = KA; msg0 = CA; key1 = KB; msg1 = CB;
    req0 = 1'b1; req1 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_valid($sformatf("fair_wait%0d", j), 30, n);
      check($sformatf("fair_spacing%0d", j), n, (j == 0) ? 7 : 8);
      check($sformatf("fair_owner%0d", j), {valid0, valid1}, (j % 2 == 0) ? 2'b10 : 2'b01);
      check($sformatf("fair_dec%0d", j), dec_out, (j % 2 == 0) ? PA : PB);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge CLK);
    check("fair_v0_count", v0_cnt - vb0, 2);
    check("fair_v1_count", v1_cnt - vb1, 2);

    // Lone req1 while rr points back at requester 0
    req1 = 1'b1;
    @(negedge CLK);
    check("solo1_grant", {grant0, grant1}, 2'b01);
    wait_valid("solo1_wait", 30, n);
    check("solo1_valid", {valid0, valid1}, 2'b01);
    check("solo1_dec", dec_out, PB);
    req1 = 1'b0;
    @(negedge CLK);

    // RESET in BUSY cycle 20 abandons the job; a new req0 then completes
    vb0 = v0_cnt + v1_cnt;
    core_lat = 30;
    key0 = KA; msg0 = CA; req0 = 1'b1;
    repeat (20) @(negedge CLK);
    check("rmid_busy20", {grant0, aes_start, valid0}, 3'b110);
    RESET = 1'b1;
    @(negedge CLK);
    check("rmid_start_low", {aes_start, grant0, valid0}, '0);
    RESET = 1'b0;
    core_lat = 4;
    wait_valid("rmid_wait", 30, n);
    check("rmid_latency", n, 7);
    check("rmid_valid", {valid0, valid1}, 2'b10);
    check("rmid_dec", dec_out, PA);
    req0 = 1'b0;
    repeat (2) @(negedge CLK);
    check("rmid_one_valid", v0_cnt + v1_cnt - vb0, 1);

    // aes_done stuck low
    core_stuck = 1'b1;
    key0 = KB; msg0 = CB; req0 = 1'b1;
`ifdef AES_ARB_TIMEOUT_EN
    repeat (15) @(negedge CLK);
    check("to_cycle15", {aes_core_reset, aes_start, valid0}, 3'b010);
    @(negedge CLK);
    check("to_cycle16_reset", {aes_core_reset, aes_start}, 2'b11);
    @(negedge CLK);
    check("to_valid_err", {valid0, err0, valid1, err1, aes_core_reset}, 5'b11000);
    check("to_dec_unchanged", dec_out, PA);
    req0 = 1'b0; core_stuck = 1'b0;
    @(negedge CLK);
    check("to_idle_after", {grant0, valid0, err0, aes_start}, '0);
`else
    repeat (40) @(negedge CLK);
    check("hang_still_busy", {grant0, aes_start, valid0, err0, aes_core_reset}, 5'b11000);
    RESET = 1'b1; req0 = 1'b0;
    @(negedge CLK);
    RESET = 1'b0; core_stuck = 1'b0;
    check("hang_reset_idle", {grant0, aes_start, valid0}, '0);
    check("hang_reset_dec", dec_out, '0);
    check("hang_reset_key", aes_key, '0);
    check("no_err_ever", err_seen, 0);
`endif
    @(negedge CLK);
    check("no_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
